traffic_phase_ctrl: RTL
=======================

Name: traffic_phase_ctrl

Overview:
- Phase sequencer for a two-road intersection with a pedestrian walk phase; it consumes the expiry pulse from traffictimer_bh.
- For each phase it programs the timer: it pulses the timer's reset and drives the timer's compare value (cnt_rst).
- It advances to the next phase on the timer pulse and drives the lamp outputs.
- It contains a watchdog that forces a latched all-red fault if the timer never fires.

Parameters:
- NBITS, 32, timer count width minus one; the count ports are NBITS+1 bits, matching traffictimer_bh.
- T_GREEN, 50, green phase duration in timer counts.
- T_YELLOW, 10, yellow phase duration in timer counts.
- T_ALLRED, 5, all-red clearance duration in timer counts.
- T_WALK, 20, pedestrian walk duration in timer counts.
- WD_SLACK, 8, extra cycles allowed beyond the expected dwell before a fault is declared.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- timer  in  1  expiry pulse from traffictimer_bh.
- ped_req  in  1  pedestrian request (level or pulse), sampled every cycle.
- tmr_rst  out  1  drives the timer's reset input.
- cnt_rst  out  NBITS+1  drives the timer's compare value.
- ns_light  out  3  north-south lamps {red,yellow,green}, one-hot.
- ew_light  out  3  east-west lamps {red,yellow,green}, one-hot.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse when a walk phase is granted.
- fault  out  1  watchdog tripped; sticky until reset.
- phase  out  3  current state encoding, for debug.

Behaviour:
- Phase cycle: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> (WALK if ped_pending, else NS_GREEN); WALK -> NS_GREEN; FAULT is terminal.
- State encodings: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, WALK=6, FAULT=7.
- Reset (async):
  - state=ALLRED_B, tmr_rst=1, cnt_rst=T_ALLRED.
  - ped_pending=0, ped_ack=0, fault=0, walk=0, dwell counter=0.
  - ns_light=ew_light=3'b100.
- Phase entry, at clock edge e:
  - state updates; tmr_rst=1 for exactly the cycle after e; cnt_rst is loaded with the new phase duration and then held constant.
  - Durations below 1 are clamped to 1, because a compare value of 0 never fires.
- Expiry qualification: expire = timer & ~tmr_rst.
  - The timer output may still be high from the previous phase during the tmr_rst cycle; the mask prevents a double advance.
- Dwell: with traffictimer_bh, a phase of duration N lasts exactly N+2 cycles (reset cycle, N counts, then the sampling edge).
- Lamps (Moore, decoded from state):
  - green/yellow states: active road shows that colour, other road red.
  - ALLRED_A, ALLRED_B, WALK, FAULT: both roads red.
  - walk=1 only in WALK.
- Pedestrian handling:
  - ped_pending is set whenever ped_req=1 and cleared on the edge entering WALK.
  - ped_ack=1 for the cycle following the ALLRED_B->WALK edge.
  - If set and clear occur in the same cycle, set wins; a request made during WALK is therefore retained for the next cycle.
- Watchdog:
  - The dwell counter (NBITS+1 bits, saturating) clears on every phase entry and increments each cycle otherwise.
  - If it reaches cnt_rst+2+WD_SLACK without expire, the next edge enters FAULT: fault=1, tmr_rst=1 held, timer ignored.
  - Only reset leaves FAULT.
- Simultaneous expire and watchdog trip: expire wins and the phase advances normally.
- Reset mid-phase: immediate return to the reset values above, regardless of timer or ped_req; the next phase after the ALLRED_B clearance is NS_GREEN.
- No combinational path from inputs to outputs; all outputs are registered or decoded from registered state.

Test Plan:
- Common setup: T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_WALK=3, WD_SLACK=4, paired with a live traffictimer_bh, ped_req=0.
- Normal cycle: release reset -> ALLRED_B 3 cycles, NS_GREEN 6, NS_YELLOW 4, ALLRED_A 3, EW_GREEN 6, EW_YELLOW 4, ALLRED_B 3, back to NS_GREEN; lamps are one-hot every cycle and no cycle has both roads non-red.
- Ped request: pulse ped_req for 1 cycle during EW_GREEN -> after ALLRED_B, WALK for 5 cycles with walk=1, ped_ack pulses once, then NS_GREEN; ped_pending=0 afterwards.
- Tie-break: ped_req held high across the ALLRED_B->WALK edge -> ped_pending remains 1 after the edge, so a second WALK occurs in the next cycle.
- Stale pulse: force timer=1 during the tmr_rst cycle of NS_GREEN -> state does not advance; NS_GREEN still lasts 6 cycles.
- Watchdog: tie timer=0 -> in NS_GREEN, at dwell count 4+2+4=10 the block enters FAULT: fault=1, all red, phase=7, remaining stuck with timer toggling; async reset clears it within the same cycle.
- Reset mid-operation: assert reset mid EW_GREEN between clock edges -> outputs return to their reset values immediately (ALLRED_B, all red, tmr_rst=1); a ped_req seen before reset is lost; after release the sequence matches the normal-cycle case.
- Clamp: T_YELLOW=0 -> cnt_rst=1 during the yellow phases and each yellow phase lasts 3 cycles.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road phase sequencer with pedestrian walk, timer programming and watchdog fault latch
module traffic_phase_ctrl #(
    parameter int NBITS    = 32,
    parameter int T_GREEN  = 50,
    parameter int T_YELLOW = 10,
    parameter int T_ALLRED = 5,
    parameter int T_WALK   = 20,
    parameter int WD_SLACK = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             timer_i,
    input  logic             ped_req_i,
    output logic             tmr_rst_o,
    output logic [NBITS:0]   cnt_rst_o,
    output logic [2:0]       ns_light_o,
    output logic [2:0]       ew_light_o,
    output logic             walk_o,
    output logic             ped_ack_o,
    output logic             fault_o,
    output logic [2:0]       phase_o
);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        WALK      = 3'd6,
        FAULT     = 3'd7
    } phase_e;

    // a compare value of 0 never fires, so every duration is at least 1
    localparam logic [NBITS:0] D_GREEN  = (NBITS+1)'(T_GREEN  < 1 ? 1 : T_GREEN);
    localparam logic [NBITS:0] D_YELLOW = (NBITS+1)'(T_YELLOW < 1 ? 1 : T_YELLOW);
    localparam logic [NBITS:0] D_ALLRED = (NBITS+1)'(T_ALLRED < 1 ? 1 : T_ALLRED);
    localparam logic [NBITS:0] D_WALK   = (NBITS+1)'(T_WALK   < 1 ? 1 : T_WALK);

    function automatic logic [NBITS:0] dur(input phase_e p);
        return (p == NS_GREEN || p == EW_GREEN) ? D_GREEN :
               (p == NS_YELLOW || p == EW_YELLOW) ? D_YELLOW :
               (p == WALK) ? D_WALK : D_ALLRED;
    endfunction

    phase_e            state_q, state_d, nxt;
    logic              tmr_rst_q, tmr_rst_d;
    logic [NBITS:0]    cnt_rst_q, cnt_rst_d;
    logic [NBITS:0]    dwell_q, dwell_d;
    logic              ped_pend_q, ped_pend_d;
    logic              ped_ack_q, ped_ack_d;
    logic              expire, wd_trip, entry, enter_walk;
    logic [NBITS+1:0]  wd_lim;

    // a timer pulse left over from the previous phase is ignored while the timer is being reset
    assign expire  = timer_i & ~tmr_rst_q;
    assign wd_lim  = {1'b0, cnt_rst_q} + (NBITS+2)'(WD_SLACK + 2);
    assign wd_trip = {1'b0, dwell_q} >= wd_lim;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ALLRED_B;
            tmr_rst_q  <= 1'b1;
            cnt_rst_q  <= D_ALLRED;
            dwell_q    <= '0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_rst_q  <= tmr_rst_d;
            cnt_rst_q  <= cnt_rst_d;
            dwell_q    <= dwell_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    always_comb begin
        nxt        = (state_q == ALLRED_B) ? (ped_pend_q ? WALK : NS_GREEN) :
                     (state_q == WALK) ? NS_GREEN : phase_e'(state_q + 3'd1);
        state_d    = (state_q == FAULT) ? FAULT : expire ? nxt : wd_trip ? FAULT : state_q;
        entry      = state_d != state_q;
        enter_walk = entry && state_d == WALK;
        tmr_rst_d  = entry || state_d == FAULT;
        cnt_rst_d  = (entry && state_d != FAULT) ? dur(state_d) : cnt_rst_q;
        dwell_d    = entry ? '0 : (&dwell_q) ? dwell_q : dwell_q + (NBITS+1)'(1);
        // a request arriving on the walk-entry edge survives for the next cycle
        ped_pend_d = ped_req_i || (ped_pend_q && !enter_walk);
        ped_ack_d  = enter_walk;
    end

    always_comb begin
        ns_light_o = (state_q == NS_GREEN) ? 3'b001 : (state_q == NS_YELLOW) ? 3'b010 : 3'b100;
        ew_light_o = (state_q == EW_GREEN) ? 3'b001 : (state_q == EW_YELLOW) ? 3'b010 : 3'b100;
        walk_o     = state_q == WALK;
        fault_o    = state_q == FAULT;
        phase_o    = state_q;
        tmr_rst_o  = tmr_rst_q;
        cnt_rst_o  = cnt_rst_q;
        ped_ack_o  = ped_ack_q;
    end
endmodule
